cr_ahbl_slv_if: RTL and testbench
=================================

Name: cr_ahbl_slv_if

Overview:
AHB-Lite responder (slave) interface. It accepts single transfers from the core's AHB-Lite master port and converts each one into a simple req/ack access on a local memory or register port. It generates HREADY wait states and the two-cycle ERROR response, so the master FSM on the other end sees a compliant peer. It sits between the bus fabric and local SRAM/peripheral register banks.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
TIMEOUT_CYC, 16, number of cycles before a local access is aborted; used only when CR_AHBL_SLV_TIMEOUT_EN is defined.

Ports:
ahbl_gated_clk  in  1  clock; all flops are rising-edge.
cpurst_b  in  1  reset; asynchronous, active-low.
ahbl_slv_hsel  in  1  slave select.
ahbl_slv_haddr  in  32  address-phase address.
ahbl_slv_htrans  in  2  transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
ahbl_slv_hwrite  in  1  1 = write.
ahbl_slv_hsize  in  3  transfer size.
ahbl_slv_hprot  in  4  protection attributes.
ahbl_slv_hwdata  in  32  data-phase write data.
ahbl_slv_hready_in  in  1  bus-level HREADY.
slv_ahbl_hready  out  1  HREADYOUT.
slv_ahbl_hresp  out  1  1 = ERROR.
slv_ahbl_hrdata  out  32  read data.
slv_req  out  1  local access request.
slv_write  out  1  local write.
slv_addr  out  32  word-aligned local address.
slv_wstrb  out  4  byte enables.
slv_wdata  out  32  local write data.
slv_prot  out  4  registered hprot.
slv_ack  in  1  local access done.
slv_err  in  1  local error; valid only with slv_ack.
slv_rdata  in  32  local read data; valid with slv_ack.
ahblsif_idle  out  1  FSM is in IDLE.

Behaviour:
- Address-phase sample: `acc = hsel && htrans[1] && hready_in`.
  - On `acc`, register haddr, hwrite, hsize, hprot.
  - If hsel is set with IDLE/BUSY, or hsel=0: no access; the data phase is a zero-wait OKAY.
- Legality check, done at sample time:
  - hsize>2 is illegal.
  - hsize=1 with haddr[0]=1 is illegal (misaligned).
  - hsize=2 with haddr[1:0]!=0 is illegal (misaligned).
- FSM states: IDLE, ACCESS, ERR1, ERR2.
  - IDLE: legal `acc` -> ACCESS; illegal `acc` -> ERR1; otherwise stay in IDLE.
  - ACCESS:
    - slv_req=1, driven combinationally while in this state; the request is issued in the data phase, so hwdata is valid.
    - slv_ack=0: hready=0, stay in ACCESS.
    - slv_ack=1, slv_err=1: -> ERR1.
    - slv_ack=1, slv_err=0: hready=1. If a legal `acc` is sampled the same cycle -> ACCESS (back-to-back); illegal `acc` -> ERR1; no `acc` -> IDLE.
  - ERR1: hready=0, hresp=1; -> ERR2.
  - ERR2: hready=1, hresp=1. Any `acc` sampled here is accepted with the IDLE rules.
- Output decode:
  - slv_addr = {haddr_q[31:2],2'b00}.
  - slv_wdata = hwdata, passed through.
  - slv_write = hwrite_q.
  - slv_wstrb:
    - byte: one-hot of addr[1:0].
    - half: 0011 or 1100 from addr[1].
    - word: 1111.
    - strobes are also driven for reads.
- Read data: hrdata = slv_rdata when ACCESS && slv_ack && !write; otherwise 0.
- Latency: minimum 1 data-phase cycle (ack in the first ACCESS cycle = zero wait); each extra ack-delay cycle adds one wait state. Error response is always exactly 2 cycles.
- slv_req never asserts outside ACCESS. Once asserted, it is held until ack; there is no withdrawal.
- Reset values: state=IDLE, hready=1, hresp=0, hrdata=0, slv_req=0, slv_write=0, slv_wstrb=0, slv_addr=0, slv_prot=0, ahblsif_idle=1.
- Reset asserted mid-access: FSM returns to IDLE asynchronously and slv_req drops immediately; the local side must tolerate an abandoned request.

Optional Feature:
CR_AHBL_SLV_TIMEOUT_EN:
- Defined:
  - 5-bit counter cleared on ACCESS entry and incremented each ACCESS cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 with no ack: drop slv_req, go to ERR1, ignore any late ack.
- Not defined: ACCESS waits indefinitely; no counter is instantiated.

Test Plan:
- Word read at 0x100, ack in the first ACCESS cycle with rdata=0xDEADBEEF -> slv_addr=0x100, wstrb=1111, zero-wait hready=1, hrdata=0xDEADBEEF, hresp=0.
- Byte write at 0x203, hwdata=0xAA000000, ack after 3 cycles -> 3 cycles hready=0, then 1; slv_write=1, wstrb=1000, slv_addr=0x200.
- Back-to-back NONSEQ write 0x10 then read 0x14, each acked immediately -> two consecutive ACCESS cycles, hready=1 both cycles, no IDLE in between.
- Half-word at 0x21 -> no slv_req; hready/hresp = 0/1 then 1/1; back to IDLE.
- Read with slv_ack=1, slv_err=1 -> ERR1 then ERR2 sequence, hrdata=0.
- With CR_AHBL_SLV_TIMEOUT_EN and TIMEOUT_CYC=16, no ack -> slv_req high for 16 cycles, then two-cycle ERROR; an ack arriving at cycle 17 is ignored.
- Reset pulse during ACCESS -> slv_req=0 and hready=1 immediately.

Source files
------------

// File: rtl/cr_ahbl_slv_if.sv
// cr_ahbl_slv_if: AHB-Lite responder that turns single transfers into a
// req/ack access on a local memory or register port. It generates HREADY
// wait states and the two-cycle ERROR response.
//
// Optional feature macro: CR_AHBL_SLV_TIMEOUT_EN
//   defined   -> a local access that goes TIMEOUT_CYC cycles without ack is
//                abandoned and answered with an ERROR response.
//   undefined -> ACCESS waits for slv_ack indefinitely; no counter exists.
//
// Handshake: slv_req is high for every cycle spent in ACCESS. Once raised it
// stays high until the cycle in which slv_ack is seen (or, with the timeout
// feature, until the timeout fires). slv_err/slv_rdata are sampled only in a
// cycle where slv_req and slv_ack are both high.
module cr_ahbl_slv_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  ahbl_gated_clk,
  input  logic                  cpurst_b,
  input  logic                  ahbl_slv_hsel,
  input  logic [31:0]           ahbl_slv_haddr,
  input  logic [1:0]            ahbl_slv_htrans,
  input  logic                  ahbl_slv_hwrite,
  input  logic [2:0]            ahbl_slv_hsize,
  input  logic [3:0]            ahbl_slv_hprot,
  input  logic [DATA_WIDTH-1:0] ahbl_slv_hwdata,
  input  logic                  ahbl_slv_hready_in,
  output logic                  slv_ahbl_hready,
  output logic                  slv_ahbl_hresp,
  output logic [DATA_WIDTH-1:0] slv_ahbl_hrdata,
  output logic                  slv_req,
  output logic                  slv_write,
  output logic [31:0]           slv_addr,
  output logic [3:0]            slv_wstrb,
  output logic [DATA_WIDTH-1:0] slv_wdata,
  output logic [3:0]            slv_prot,
  input  logic                  slv_ack,
  input  logic                  slv_err,
  input  logic [DATA_WIDTH-1:0] slv_rdata,
  output logic                  ahblsif_idle
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_acc;
  logic        w_legal;
  logic [3:0]  w_wstrb_d;
  logic        w_timeout;

  logic [29:0] r_addr_word;
  logic        r_hwrite;
  logic [3:0]  r_hprot;
  logic [3:0]  r_wstrb;

  // A transfer is accepted only when selected, NONSEQ/SEQ, and the bus is ready.
  assign w_acc = ahbl_slv_hsel & ahbl_slv_htrans[1] & ahbl_slv_hready_in;

  // Size/alignment legality and byte-lane decode, evaluated in the address phase.
  always_comb begin
    w_legal   = 1'b0;
    w_wstrb_d = 4'b0000;
    case (ahbl_slv_hsize)
      3'd0: begin
        w_legal   = 1'b1;
        w_wstrb_d = 4'b0001 << ahbl_slv_haddr[1:0];
      end
      3'd1: begin
        w_legal   = ~ahbl_slv_haddr[0];
        w_wstrb_d = ahbl_slv_haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        w_legal   = (ahbl_slv_haddr[1:0] == 2'b00);
        w_wstrb_d = 4'b1111;
      end
      default: begin
        w_legal   = 1'b0;
        w_wstrb_d = 4'b0000;
      end
    endcase
  end

  // Capture the address-phase attributes of every accepted transfer.
  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_addr_word <= '0;
      r_hwrite    <= 1'b0;
      r_hprot     <= '0;
      r_wstrb     <= '0;
    end else if (w_acc) begin
      r_addr_word <= ahbl_slv_haddr[31:2];
      r_hwrite    <= ahbl_slv_hwrite;
      r_hprot     <= ahbl_slv_hprot;
      r_wstrb     <= w_wstrb_d;
    end
  end

`ifdef CR_AHBL_SLV_TIMEOUT_EN
  logic [4:0] r_to_cnt;

  // Count ACCESS cycles without ack; any cycle not waiting in ACCESS clears it,
  // so the count always starts from zero on ACCESS entry.
  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !slv_ack) begin
      r_to_cnt <= r_to_cnt + 5'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_to_cnt == 5'(TIMEOUT_CYC - 1));
`else
  logic [31:0] w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout            = 1'b0;
`endif

  // State register; reset forces IDLE immediately, abandoning any request.
  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all bus/local handshake outputs.
  always_comb begin
    w_state_nxt     = r_state;
    slv_ahbl_hready = 1'b1;
    slv_ahbl_hresp  = 1'b0;
    slv_ahbl_hrdata = '0;
    slv_req         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_state_nxt = w_legal ? ST_ACCESS : ST_ERR1;
        end
      end
      ST_ACCESS: begin
        slv_req = 1'b1;
        if (slv_ack) begin
          if (!r_hwrite) begin
            slv_ahbl_hrdata = slv_rdata;
          end
          if (slv_err) begin
            slv_ahbl_hready = 1'b0;
            w_state_nxt     = ST_ERR1;
          end else if (w_acc) begin
            w_state_nxt = w_legal ? ST_ACCESS : ST_ERR1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          slv_ahbl_hready = 1'b0;
          if (w_timeout) begin
            w_state_nxt = ST_ERR1;
          end
        end
      end
      ST_ERR1: begin
        slv_ahbl_hready = 1'b0;
        slv_ahbl_hresp  = 1'b1;
        w_state_nxt     = ST_ERR2;
      end
      ST_ERR2: begin
        slv_ahbl_hresp = 1'b1;
        if (w_acc) begin
          w_state_nxt = w_legal ? ST_ACCESS : ST_ERR1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign slv_addr     = {r_addr_word, 2'b00};
  assign slv_write    = r_hwrite;
  assign slv_wstrb    = r_wstrb;
  assign slv_prot     = r_hprot;
  assign slv_wdata    = ahbl_slv_hwdata;
  assign ahblsif_idle = (r_state == ST_IDLE);

endmodule

// File: tb/tb_cr_ahbl_slv_if.sv
// Directed bench for cr_ahbl_slv_if. Inputs change 1 ns after the rising
// edge, outputs are checked 3 ns after the rising edge.
module tb_cr_ahbl_slv_if;

  logic        clk;
  logic        rst_b;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [3:0]  prot;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        idle;

  int checks = 0;
  int errors = 0;

  cr_ahbl_slv_if dut (
    .ahbl_gated_clk     (clk),
    .cpurst_b           (rst_b),
    .ahbl_slv_hsel      (hsel),
    .ahbl_slv_haddr     (haddr),
    .ahbl_slv_htrans    (htrans),
    .ahbl_slv_hwrite    (hwrite),
    .ahbl_slv_hsize     (hsize),
    .ahbl_slv_hprot     (hprot),
    .ahbl_slv_hwdata    (hwdata),
    .ahbl_slv_hready_in (hready_in),
    .slv_ahbl_hready    (hready),
    .slv_ahbl_hresp     (hresp),
    .slv_ahbl_hrdata    (hrdata),
    .slv_req            (req),
    .slv_write          (wr),
    .slv_addr           (addr),
    .slv_wstrb          (wstrb),
    .slv_wdata          (wdata),
    .slv_prot           (prot),
    .slv_ack            (ack),
    .slv_err            (err),
    .slv_rdata          (rdata),
    .ahblsif_idle       (idle)
  );

  // Single responder on the bus: the bus-level HREADY is its own HREADYOUT.
  assign hready_in = hready;

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [3:0] p);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    hprot  = p;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hprot  = 4'h0;
  endtask

  task automatic local_resp(input logic a, input logic e, input logic [31:0] d);
    ack   = a;
    err   = e;
    rdata = d;
  endtask

  initial begin
    rst_b  = 1'b0;
    hwdata = 32'h0;
    bus_idle();
    local_resp(1'b0, 1'b0, 32'h0);

    // Reset values
    #3;
    chk("rst_hready", {31'd0, hready}, 32'd1);
    chk("rst_hresp", {31'd0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_write", {31'd0, wr}, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_prot", {28'd0, prot}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    #9 rst_b = 1'b1;

    // Word read at 0x100, zero wait
    tick();
    addr_phase(32'h100, 1'b0, 3'd2, 4'h3);
    settle();
    chk("rd_idle_before", {31'd0, idle}, 32'd1);
    tick();
    bus_idle();
    local_resp(1'b1, 1'b0, 32'hDEADBEEF);
    settle();
    chk("rd_req", {31'd0, req}, 32'd1);
    chk("rd_addr", addr, 32'h100);
    chk("rd_wstrb", {28'd0, wstrb}, 32'hF);
    chk("rd_write", {31'd0, wr}, 32'd0);
    chk("rd_prot", {28'd0, prot}, 32'h3);
    chk("rd_hready", {31'd0, hready}, 32'd1);
    chk("rd_hresp", {31'd0, hresp}, 32'd0);
    chk("rd_hrdata", hrdata, 32'hDEADBEEF);
    tick();
    local_resp(1'b0, 1'b0, 32'hDEADBEEF);
    settle();
    chk("rd_idle_after", {31'd0, idle}, 32'd1);
    chk("rd_req_after", {31'd0, req}, 32'd0);
    chk("rd_hrdata_after", hrdata, 32'd0);

    // Byte write at 0x203, ack on the fourth ACCESS cycle
    addr_phase(32'h203, 1'b1, 3'd0, 4'h1);
    tick();
    bus_idle();
    hwdata = 32'hAA000000;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bw_wait_hready", {31'd0, hready}, 32'd0);
      chk("bw_wait_req", {31'd0, req}, 32'd1);
      tick();
    end
    local_resp(1'b1, 1'b0, 32'h55555555);
    settle();
    chk("bw_hready", {31'd0, hready}, 32'd1);
    chk("bw_write", {31'd0, wr}, 32'd1);
    chk("bw_wstrb", {28'd0, wstrb}, 32'h8);
    chk("bw_addr", addr, 32'h200);
    chk("bw_wdata", wdata, 32'hAA000000);
    chk("bw_hrdata", hrdata, 32'd0);
    tick();
    local_resp(1'b0, 1'b0, 32'h0);
    hwdata = 32'h0;
    settle();
    chk("bw_idle_after", {31'd0, idle}, 32'd1);

    // Back-to-back write 0x10 then read 0x14
    addr_phase(32'h10, 1'b1, 3'd2, 4'h2);
    tick();
    hwdata = 32'h11223344;
    local_resp(1'b1, 1'b0, 32'h0);
    addr_phase(32'h14, 1'b0, 3'd2, 4'h2);
    settle();
    chk("b2b_w_hready", {31'd0, hready}, 32'd1);
    chk("b2b_w_write", {31'd0, wr}, 32'd1);
    chk("b2b_w_addr", addr, 32'h10);
    chk("b2b_w_wdata", wdata, 32'h11223344);
    tick();
    bus_idle();
    hwdata = 32'h0;
    local_resp(1'b1, 1'b0, 32'hCAFEF00D);
    settle();
    chk("b2b_r_idle", {31'd0, idle}, 32'd0);
    chk("b2b_r_req", {31'd0, req}, 32'd1);
    chk("b2b_r_write", {31'd0, wr}, 32'd0);
    chk("b2b_r_addr", addr, 32'h14);
    chk("b2b_r_hready", {31'd0, hready}, 32'd1);
    chk("b2b_r_hrdata", hrdata, 32'hCAFEF00D);
    tick();
    local_resp(1'b0, 1'b0, 32'h0);
    settle();
    chk("b2b_idle_after", {31'd0, idle}, 32'd1);

    // Legal half-word read at 0x22 drives the upper lanes
    addr_phase(32'h22, 1'b0, 3'd1, 4'h0);
    tick();
    bus_idle();
    local_resp(1'b1, 1'b0, 32'h0000BEEF);
    settle();
    chk("hw_wstrb", {28'd0, wstrb}, 32'hC);
    chk("hw_addr", addr, 32'h20);
    chk("hw_hready", {31'd0, hready}, 32'd1);
    tick();
    local_resp(1'b0, 1'b0, 32'h0);

    // Selected BUSY transfer is not an access
    hsel   = 1'b1;
    htrans = 2'b01;
    haddr  = 32'h300;
    tick();
    bus_idle();
    settle();
    chk("busy_idle", {31'd0, idle}, 32'd1);
    chk("busy_req", {31'd0, req}, 32'd0);
    chk("busy_hready", {31'd0, hready}, 32'd1);

    // Misaligned half-word at 0x21: two-cycle ERROR, no local request
    addr_phase(32'h21, 1'b0, 3'd1, 4'h0);
    tick();
    bus_idle();
    settle();
    chk("mis_e1_req", {31'd0, req}, 32'd0);
    chk("mis_e1_hready", {31'd0, hready}, 32'd0);
    chk("mis_e1_hresp", {31'd0, hresp}, 32'd1);
    tick();
    settle();
    chk("mis_e2_req", {31'd0, req}, 32'd0);
    chk("mis_e2_hready", {31'd0, hready}, 32'd1);
    chk("mis_e2_hresp", {31'd0, hresp}, 32'd1);
    tick();
    settle();
    chk("mis_idle", {31'd0, idle}, 32'd1);
    chk("mis_hresp_after", {31'd0, hresp}, 32'd0);

    // Oversized transfer (hsize=3) is also illegal
    addr_phase(32'h40, 1'b0, 3'd3, 4'h0);
    tick();
    bus_idle();
    settle();
    chk("big_e1_hresp", {31'd0, hresp}, 32'd1);
    chk("big_e1_req", {31'd0, req}, 32'd0);
    tick();
    tick();

    // Local error on a read, then a new access accepted during ERR2
    addr_phase(32'h40, 1'b0, 3'd2, 4'h0);
    tick();
    bus_idle();
    local_resp(1'b1, 1'b1, 32'h12345678);
    settle();
    chk("lerr_ack_hready", {31'd0, hready}, 32'd0);
    chk("lerr_ack_hresp", {31'd0, hresp}, 32'd0);
    tick();
    local_resp(1'b0, 1'b0, 32'h0);
    settle();
    chk("lerr_e1_hready", {31'd0, hready}, 32'd0);
    chk("lerr_e1_hresp", {31'd0, hresp}, 32'd1);
    chk("lerr_e1_hrdata", hrdata, 32'd0);
    chk("lerr_e1_req", {31'd0, req}, 32'd0);
    tick();
    addr_phase(32'h44, 1'b0, 3'd2, 4'h0);
    settle();
    chk("lerr_e2_hready", {31'd0, hready}, 32'd1);
    chk("lerr_e2_hresp", {31'd0, hresp}, 32'd1);
    chk("lerr_e2_hrdata", hrdata, 32'd0);
    tick();
    bus_idle();
    local_resp(1'b1, 1'b0, 32'h0BADF00D);
    settle();
    chk("after_err_req", {31'd0, req}, 32'd1);
    chk("after_err_addr", addr, 32'h44);
    chk("after_err_hrdata", hrdata, 32'h0BADF00D);
    tick();
    local_resp(1'b0, 1'b0, 32'h0);
    settle();
    chk("after_err_idle", {31'd0, idle}, 32'd1);

`ifdef CR_AHBL_SLV_TIMEOUT_EN
    // No ack: 16 request cycles, then ERROR; a late ack is ignored
    addr_phase(32'h80, 1'b0, 3'd2, 4'h0);
    tick();
    bus_idle();
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("to_req", {31'd0, req}, 32'd1);
      chk("to_hready", {31'd0, hready}, 32'd0);
      tick();
    end
    local_resp(1'b1, 1'b0, 32'hFFFFFFFF);
    settle();
    chk("to_e1_req", {31'd0, req}, 32'd0);
    chk("to_e1_hready", {31'd0, hready}, 32'd0);
    chk("to_e1_hresp", {31'd0, hresp}, 32'd1);
    chk("to_e1_hrdata", hrdata, 32'd0);
    tick();
    local_resp(1'b0, 1'b0, 32'h0);
    settle();
    chk("to_e2_hready", {31'd0, hready}, 32'd1);
    chk("to_e2_hresp", {31'd0, hresp}, 32'd1);
    tick();
    settle();
    chk("to_idle", {31'd0, idle}, 32'd1);
`endif

    // Reset pulse in the middle of an access
    addr_phase(32'h100, 1'b1, 3'd2, 4'h0);
    tick();
    bus_idle();
    settle();
    chk("rmid_req_before", {31'd0, req}, 32'd1);
    chk("rmid_hready_before", {31'd0, hready}, 32'd0);
    rst_b = 1'b0;
    #1;
    chk("rmid_req", {31'd0, req}, 32'd0);
    chk("rmid_hready", {31'd0, hready}, 32'd1);
    chk("rmid_idle", {31'd0, idle}, 32'd1);
    chk("rmid_addr", addr, 32'd0);
    #1 rst_b = 1'b1;
    tick();
    settle();
    chk("rmid_idle_after", {31'd0, idle}, 32'd1);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
